// File: rtl/rv_mdu_pkg.sv
// rv_mdu_pkg: shared types and constants for the RV32M multiply/divide unit.
//   mdu_op_t    - funct3 encodings of the M-extension operations
//   mdu_state_t - control states of rv_mdu
//   MDU_DIV_ZERO_Q / MDU_OVF_Q - architectural special-case quotients
//   neg_if      - conditional two's-complement helper
package rv_mdu_pkg;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'd0,
    MDU_MULH   = 3'd1,
    MDU_MULHSU = 3'd2,
    MDU_MULHU  = 3'd3,
    MDU_DIV    = 3'd4,
    MDU_DIVU   = 3'd5,
    MDU_REM    = 3'd6,
    MDU_REMU   = 3'd7
  } mdu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } mdu_state_t;

  localparam logic [31:0] MDU_DIV_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] MDU_OVF_Q      = 32'h8000_0000;

  function automatic logic [31:0] neg_if(input logic n, input logic [31:0] v);
    return n ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/rv_mdu_step.sv
// rv_mdu_step: one combinational iteration of the shared mul/div datapath.
// Ports:
//   is_div   - 1: restoring-divide step, 0: shift-add multiply step
//   acc      - 65-bit working register {carry, hi, lo} / {R(33), Q(32)}
//   opnd     - |op1| for multiply (addend), |op2| for divide (divisor)
//   acc_next - register value after this iteration
module rv_mdu_step (
  input  logic        is_div,
  input  logic [64:0] acc,
  input  logic [31:0] opnd,
  output logic [64:0] acc_next
);

  logic [32:0] sum;
  logic [32:0] r_shift;
  logic [33:0] trial;
  logic        ge;

  always_comb begin
    // Multiply: conditionally add into the high half, then shift right.
    sum = {acc[64], acc[63:32]};
    if (acc[0]) begin
      sum = {1'b0, acc[63:32]} + {1'b0, opnd};
    end

    // Divide: shift {R,Q} left; R needs 33 bits here since 2R+1 can exceed 32 bits.
    r_shift = {acc[63:32], acc[31]};
    trial   = {1'b0, r_shift} - {2'b00, opnd};
    ge      = ~trial[33];

    if (is_div) begin
      acc_next = {(ge ? trial[32:0] : r_shift), acc[30:0], ge};
    end else begin
      acc_next = {1'b0, sum, acc[31:1]};
    end
  end

endmodule

// File: rtl/rv_mdu.sv
// rv_mdu: iterative RV32M multiply/divide unit for the ALU2 stage.
// Accepts one operation at a time; o_ready low while busy stalls the pipeline.
// Ports:
//   i_clk, i_reset (async, active-high), i_flush (sync abort, highest priority)
//   i_start/i_funct3/i_op1/i_op2/i_rd - operation, sampled only at acceptance
//   o_ready  - can accept (IDLE or DONE)
//   o_valid  - o_result/o_rd valid (DONE, one cycle)
//   o_result - registered 32-bit result, o_rd - registered destination
// Config: define RV_MDU_FAST_MUL_EN for single-cycle multiplies.
module rv_mdu
  import rv_mdu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_flush,
  input  logic            i_start,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_op1,
  input  logic [XLEN-1:0] i_op2,
  input  logic [4:0]      i_rd,
  output logic            o_ready,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result,
  output logic [4:0]      o_rd
);

  mdu_state_t  state;
  logic [4:0]  cnt;
  logic [64:0] acc;
  logic [31:0] opnd;
  mdu_op_t     op_q;
  logic        neg_q;
  logic [4:0]  rd_q;
  logic [64:0] step_next;

  // Decode of the incoming operation
  mdu_op_t     op_in;
  logic        in_is_div;
  logic        s1_signed, s2_signed;
  logic        sgn1, sgn2;
  logic [31:0] abs1, abs2;
  logic        neg_in;
  logic        div_zero, ovf, special;
  logic [31:0] special_res;
  logic        fast_take;
  logic [31:0] fast_res;

  assign op_in     = mdu_op_t'(i_funct3);
  assign in_is_div = i_funct3[2];

  always_comb begin
    s1_signed = 1'b0;
    s2_signed = 1'b0;
    case (op_in)
      MDU_MUL, MDU_MULH, MDU_DIV, MDU_REM: begin
        s1_signed = 1'b1;
        s2_signed = 1'b1;
      end
      MDU_MULHSU: s1_signed = 1'b1;
      default: ;
    endcase

    sgn1 = s1_signed & i_op1[31];
    sgn2 = s2_signed & i_op2[31];
    abs1 = neg_if(sgn1, i_op1);
    abs2 = neg_if(sgn2, i_op2);
    // Remainder takes the dividend's sign; everything else the product/quotient sign.
    neg_in = (op_in == MDU_REM) ? sgn1 : (sgn1 ^ sgn2);

    div_zero = in_is_div && (i_op2 == '0);
    ovf      = ((op_in == MDU_DIV) || (op_in == MDU_REM)) &&
               (i_op1 == 32'h8000_0000) && (i_op2 == '1);
    special  = div_zero || ovf;

    if (div_zero) begin
      special_res = i_funct3[1] ? i_op1 : MDU_DIV_ZERO_Q;
    end else begin
      special_res = i_funct3[1] ? '0 : MDU_OVF_Q;
    end
  end

`ifdef RV_MDU_FAST_MUL_EN
  logic [32:0] fa, fb;
  logic [65:0] fprod;
  always_comb begin
    fa        = {s1_signed & i_op1[31], i_op1};
    fb        = {s2_signed & i_op2[31], i_op2};
    // Sign-extended operands make an unsigned 66-bit multiply yield the signed product.
    fprod     = {{33{fa[32]}}, fa} * {{33{fb[32]}}, fb};
    fast_take = ~in_is_div;
    fast_res  = (op_in == MDU_MUL) ? fprod[31:0] : fprod[63:32];
  end
`else
  assign fast_take = 1'b0;
  assign fast_res  = '0;
`endif

  rv_mdu_step u_step (
    .is_div   (op_q[2]),
    .acc      (acc),
    .opnd     (opnd),
    .acc_next (step_next)
  );

  // Result of the final iteration, formed from the step output so it registers on DONE entry.
  logic [63:0] prod_s;
  logic [31:0] calc_res;
  always_comb begin
    prod_s = neg_q ? (~step_next[63:0] + 64'd1) : step_next[63:0];
    case (op_q)
      MDU_MUL:                         calc_res = prod_s[31:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU: calc_res = prod_s[63:32];
      MDU_DIV, MDU_DIVU:               calc_res = neg_if(neg_q, step_next[31:0]);
      default:                         calc_res = neg_if(neg_q, step_next[63:32]);
    endcase
  end

  assign o_ready = (state != ST_CALC);
  assign o_valid = (state == ST_DONE);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      op_q     <= MDU_MUL;
      neg_q    <= 1'b0;
      rd_q     <= '0;
      o_result <= '0;
      o_rd     <= '0;
    end else if (i_flush) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            op_q  <= op_in;
            neg_q <= neg_in;
            rd_q  <= i_rd;
            if (special) begin
              state    <= ST_DONE;
              o_result <= special_res;
              o_rd     <= i_rd;
            end else if (fast_take) begin
              state    <= ST_DONE;
              o_result <= fast_res;
              o_rd     <= i_rd;
            end else begin
              state <= ST_CALC;
              cnt   <= 5'd31;
              acc   <= {33'd0, (in_is_div ? abs1 : abs2)};
              opnd  <= in_is_div ? abs2 : abs1;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_CALC: begin
          acc <= step_next;
          cnt <= cnt - 5'd1;
          if (cnt == '0) begin
            state    <= ST_DONE;
            o_result <= calc_res;
            o_rd     <= rd_q;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_mdu.sv
module tb_rv_mdu;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_flush;
  logic        i_start;
  logic [2:0]  i_funct3;
  logic [31:0] i_op1, i_op2;
  logic [4:0]  i_rd;
  logic        o_ready, o_valid;
  logic [31:0] o_result;
  logic [4:0]  o_rd;

  int errors = 0;
  int checks = 0;

`ifdef RV_MDU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  rv_mdu #(.XLEN(32)) dut (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_flush  (i_flush),
    .i_start  (i_start),
    .i_funct3 (i_funct3),
    .i_op1    (i_op1),
    .i_op2    (i_op2),
    .i_rd     (i_rd),
    .o_ready  (o_ready),
    .o_valid  (o_valid),
    .o_result (o_result),
    .o_rd     (o_rd)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at a negedge; issues v and waits for o_valid (bounded).
  task automatic run(input vec_t v, input string nm);
    int n;
    int lowcnt;
    bit seen;
    n = 0; lowcnt = 0; seen = 0;
    i_start = 1'b1; i_funct3 = v.f3; i_op1 = v.a; i_op2 = v.b; i_rd = v.rd;
    while (n < 40 && !seen) begin
      @(negedge i_clk);
      if (n == 0) begin
        // Scramble inputs after acceptance; the unit must ignore them.
        i_start = 1'b0;
        i_op1 = $urandom; i_op2 = $urandom;
        i_funct3 = 3'($urandom); i_rd = 5'($urandom);
      end
      n++;
      if (o_valid) seen = 1;
      else if (!o_ready) lowcnt++;
    end
    chk({nm, "_latency"}, seen ? n : 0, v.lat);
    chk({nm, "_result"}, o_result, v.exp);
    chk({nm, "_rd"}, {27'd0, o_rd}, {27'd0, v.rd});
    chk({nm, "_busy_cycles"}, lowcnt, v.lat - 1);
  endtask

  initial begin
    int lows;
    int vals;
    vecs[0]  = '{3'd0, 32'h7,        32'hFFFFFFFD, 5'd1,  32'hFFFFFFEB, MUL_LAT};
    vecs[1]  = '{3'd1, 32'h80000000, 32'h80000000, 5'd2,  32'h40000000, MUL_LAT};
    vecs[2]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFE, MUL_LAT};
    vecs[3]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'hFFFFFFFF, MUL_LAT};
    vecs[4]  = '{3'd0, 32'h12345678, 32'h10,       5'd5,  32'h23456780, MUL_LAT};
    vecs[5]  = '{3'd1, 32'h12345678, 32'h10,       5'd6,  32'h00000001, MUL_LAT};
    vecs[6]  = '{3'd4, 32'hFFFFFFF9, 32'h2,        5'd7,  32'hFFFFFFFD, DIV_LAT};
    vecs[7]  = '{3'd6, 32'hFFFFFFF9, 32'h2,        5'd8,  32'hFFFFFFFF, DIV_LAT};
    vecs[8]  = '{3'd5, 32'd100,      32'd7,        5'd9,  32'd14,       DIV_LAT};
    vecs[9]  = '{3'd7, 32'd100,      32'd7,        5'd10, 32'd2,        DIV_LAT};
    vecs[10] = '{3'd4, 32'd20,       32'hFFFFFFFD, 5'd11, 32'hFFFFFFFA, DIV_LAT};
    vecs[11] = '{3'd6, 32'd20,       32'hFFFFFFFD, 5'd12, 32'd2,        DIV_LAT};
    vecs[12] = '{3'd4, 32'd5,        32'd0,        5'd13, 32'hFFFFFFFF, 1};
    vecs[13] = '{3'd6, 32'd5,        32'd0,        5'd14, 32'd5,        1};
    vecs[14] = '{3'd5, 32'd5,        32'd0,        5'd15, 32'hFFFFFFFF, 1};
    vecs[15] = '{3'd7, 32'd5,        32'd0,        5'd16, 32'd5,        1};
    vecs[16] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd17, 32'h80000000, 1};
    vecs[17] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd18, 32'd0,        1};
    vecs[18] = '{3'd5, 32'd9,        32'd3,        5'd19, 32'd3,        DIV_LAT};
    vecs[19] = '{3'd5, 32'hFFFFFFFF, 32'd1,        5'd31, 32'hFFFFFFFF, DIV_LAT};

    i_reset = 1'b1; i_flush = 1'b0; i_start = 1'b0;
    i_funct3 = '0; i_op1 = '0; i_op2 = '0; i_rd = '0;
    repeat (2) @(negedge i_clk);
    chk("reset_ready", {31'd0, o_ready}, 32'd1);
    chk("reset_valid", {31'd0, o_valid}, 32'd0);
    chk("reset_result", o_result, 32'd0);
    chk("reset_rd", {27'd0, o_rd}, 32'd0);
    i_reset = 1'b0;
    @(negedge i_clk);

    for (int i = 0; i < 20; i++) begin
      run(vecs[i], $sformatf("vec%0d", i));
      @(negedge i_clk);
      chk($sformatf("vec%0d_valid_drop", i), {31'd0, o_valid}, 32'd0);
    end

    // Flush on the 10th CALC cycle
    i_start = 1'b1; i_funct3 = 3'd5; i_op1 = 32'd100; i_op2 = 32'd7; i_rd = 5'd9;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (9) @(negedge i_clk);
    i_flush = 1'b1;
    @(negedge i_clk);
    i_flush = 1'b0;
    chk("flush_ready", {31'd0, o_ready}, 32'd1);
    chk("flush_valid", {31'd0, o_valid}, 32'd0);
    vals = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge i_clk);
      if (o_valid) vals++;
    end
    chk("flush_no_valid", vals, 0);
    run(vecs[18], "after_flush");

    // Flush and start together: start ignored
    @(negedge i_clk);
    i_start = 1'b1; i_flush = 1'b1; i_funct3 = 3'd5; i_op1 = 32'd100; i_op2 = 32'd7;
    @(negedge i_clk);
    i_start = 1'b0; i_flush = 1'b0;
    chk("flush_start_ready", {31'd0, o_ready}, 32'd1);
    lows = 0; vals = 0;
    for (int k = 0; k < 36; k++) begin
      @(negedge i_clk);
      if (!o_ready) lows++;
      if (o_valid) vals++;
    end
    chk("flush_start_busy", lows, 0);
    chk("flush_start_valid", vals, 0);

    // Asynchronous reset mid-CALC
    run(vecs[8], "pre_reset");
    @(negedge i_clk);
    i_start = 1'b1; i_funct3 = 3'd5; i_op1 = 32'd100; i_op2 = 32'd7; i_rd = 5'd21;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (4) @(negedge i_clk);
    #2 i_reset = 1'b1;
    #1;
    chk("async_reset_ready", {31'd0, o_ready}, 32'd1);
    chk("async_reset_valid", {31'd0, o_valid}, 32'd0);
    chk("async_reset_result", o_result, 32'd0);
    chk("async_reset_rd", {27'd0, o_rd}, 32'd0);
    @(negedge i_clk);
    i_reset = 1'b0;
    @(negedge i_clk);

    // Back-to-back: second start issued in the DONE cycle of the first
    run(vecs[6], "b2b_first");
    run(vecs[9], "b2b_second");
    run(vecs[16], "b2b_special");
    @(negedge i_clk);
    chk("b2b_valid_drop", {31'd0, o_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
